// File: rtl/jb_oran_lphy_seq_pkg.sv
// rtl/jb_oran_lphy_seq_pkg.sv - shared types for the low-PHY reset sequencer
package jb_oran_lphy_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BND = 3'd1,
        CLEAR    = 3'd2,
        RESET    = 3'd3,
        SETTLE   = 3'd4,
        DONE     = 3'd5
    } seq_state_e;

    typedef enum logic {
        UL    = 1'b0,
        PRACH = 1'b1
    } seq_path_e;

    // Bit position of a path inside the {prach, ul} pending vector
    function automatic logic [1:0] path_bit(seq_path_e p);
        return (p == UL) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/jb_oran_lphy_rst_seq_if.sv
// rtl/jb_oran_lphy_rst_seq_if.sv - low-PHY control clear/reset fields
interface jb_oran_lphy_rst_seq_if;

    logic ul_lphy_oran_clear;
    logic ul_lphy_oran_fifo_reset;
    logic prach_oran_clear;
    logic prach_oran_fifo_reset;
    logic lphy_oran_dbg_clear;

    modport master (
        output ul_lphy_oran_clear,
        output ul_lphy_oran_fifo_reset,
        output prach_oran_clear,
        output prach_oran_fifo_reset,
        output lphy_oran_dbg_clear
    );

    modport slave (
        input ul_lphy_oran_clear,
        input ul_lphy_oran_fifo_reset,
        input prach_oran_clear,
        input prach_oran_fifo_reset,
        input lphy_oran_dbg_clear
    );

endinterface

// File: rtl/jb_oran_lphy_rr_arb2.sv
// rtl/jb_oran_lphy_rr_arb2.sv - two-way round-robin arbiter for UL/PRACH requests
module jb_oran_lphy_rr_arb2
    import jb_oran_lphy_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output seq_path_e  gnt_path
);

    seq_path_e last_q;
    seq_path_e last_d;

    // On a tie the path not served last wins; PRACH at reset lets UL win first
    always_comb begin
        gnt_valid = |req;
        gnt_path  = UL;
        if (req == 2'b11) begin
            gnt_path = (last_q == UL) ? PRACH : UL;
        end else if (req[1]) begin
            gnt_path = PRACH;
        end
        last_d = (accept && gnt_valid) ? gnt_path : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PRACH;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/jb_oran_lphy_rst_seq.sv
// rtl/jb_oran_lphy_rst_seq.sv - symbol-aligned clear/FIFO-reset sequencer for UL and PRACH
module jb_oran_lphy_rst_seq
    import jb_oran_lphy_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int BND_TIMEOUT   = 65535,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ul_req,
    input  logic                          prach_req,
    input  logic                          dbg_clear_req,
    input  logic                          sym_strobe,
    jb_oran_lphy_rst_seq_if.master        ctrl,
    output logic                          ul_busy,
    output logic                          prach_busy,
    output logic                          ul_done,
    output logic                          prach_done,
    output logic                          bnd_timeout_err
);

    localparam logic [CNT_W-1:0] BND_LAST = CNT_W'(BND_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q, state_d;
    seq_path_e        sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic             err_q, err_d;

    logic ul_clr_q, ul_clr_d, ul_fr_q, ul_fr_d, ul_done_q, ul_done_d, ul_busy_q, ul_busy_d;
    logic pr_clr_q, pr_clr_d, pr_fr_q, pr_fr_d, pr_done_q, pr_done_d, pr_busy_q, pr_busy_d;
    logic dbg_q, dbg_d;

    logic      arb_accept;
    logic      gnt_valid;
    seq_path_e gnt_path;

    jb_oran_lphy_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend_q),
        .accept    (arb_accept),
        .gnt_valid (gnt_valid),
        .gnt_path  (gnt_path)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= UL;
            cnt_q     <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            ul_clr_q  <= 1'b0;
            ul_fr_q   <= 1'b0;
            ul_done_q <= 1'b0;
            ul_busy_q <= 1'b0;
            pr_clr_q  <= 1'b0;
            pr_fr_q   <= 1'b0;
            pr_done_q <= 1'b0;
            pr_busy_q <= 1'b0;
            dbg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            ul_clr_q  <= ul_clr_d;
            ul_fr_q   <= ul_fr_d;
            ul_done_q <= ul_done_d;
            ul_busy_q <= ul_busy_d;
            pr_clr_q  <= pr_clr_d;
            pr_fr_q   <= pr_fr_d;
            pr_done_q <= pr_done_d;
            pr_busy_q <= pr_busy_d;
            dbg_q     <= dbg_d;
        end
    end

    // DONE arbitrates like IDLE so a queued path starts WAIT_BND right after
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        arb_accept = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (gnt_valid) begin
                    arb_accept = 1'b1;
                    sel_d      = gnt_path;
                    cnt_d      = '0;
                    state_d    = WAIT_BND;
                end
            end
            WAIT_BND: begin
                if (sym_strobe) begin
                    state_d = CLEAR;
                end else if (cnt_q == BND_LAST) begin
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RESET;
            end
            RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~(arb_accept ? path_bit(gnt_path) : 2'b00)) | {prach_req, ul_req};
    end

    // Outputs decode the next state so every control leaves a flop
    always_comb begin
        ul_clr_d  = (state_d == CLEAR)  && (sel_d == UL);
        ul_fr_d   = (state_d == RESET)  && (sel_d == UL);
        ul_done_d = (state_d == DONE)   && (sel_d == UL);
        ul_busy_d = pend_d[0] || ((state_d != IDLE) && (sel_d == UL));
        pr_clr_d  = (state_d == CLEAR)  && (sel_d == PRACH);
        pr_fr_d   = (state_d == RESET)  && (sel_d == PRACH);
        pr_done_d = (state_d == DONE)   && (sel_d == PRACH);
        pr_busy_d = pend_d[1] || ((state_d != IDLE) && (sel_d == PRACH));
        dbg_d     = dbg_clear_req;
    end

    assign ctrl.ul_lphy_oran_clear      = ul_clr_q;
    assign ctrl.ul_lphy_oran_fifo_reset = ul_fr_q;
    assign ctrl.prach_oran_clear        = pr_clr_q;
    assign ctrl.prach_oran_fifo_reset   = pr_fr_q;
    assign ctrl.lphy_oran_dbg_clear     = dbg_q;
    assign ul_busy                      = ul_busy_q;
    assign prach_busy                   = pr_busy_q;
    assign ul_done                      = ul_done_q;
    assign prach_done                   = pr_done_q;
    assign bnd_timeout_err              = err_q;

endmodule

// File: tb/tb_jb_oran_lphy_rst_seq.sv
// tb/tb_jb_oran_lphy_rst_seq.sv - directed self-checking bench for jb_oran_lphy_rst_seq
module tb_jb_oran_lphy_rst_seq;

    logic clk = 1'b0;
    logic rst;
    logic ul_req, prach_req, dbg_clear_req, sym_strobe;
    logic ul_busy, prach_busy, ul_done, prach_done, bnd_timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jb_oran_lphy_rst_seq_if ctrl_if ();

    jb_oran_lphy_rst_seq #(
        .RST_CYCLES    (16),
        .SETTLE_CYCLES (8),
        .BND_TIMEOUT   (100),
        .CNT_W         (16)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ul_req          (ul_req),
        .prach_req       (prach_req),
        .dbg_clear_req   (dbg_clear_req),
        .sym_strobe      (sym_strobe),
        .ctrl            (ctrl_if),
        .ul_busy         (ul_busy),
        .prach_busy      (prach_busy),
        .ul_done         (ul_done),
        .prach_done      (prach_done),
        .bnd_timeout_err (bnd_timeout_err)
    );

    // {ul_clear, ul_fifo_reset, ul_done, pr_clear, pr_fifo_reset, pr_done, ul_busy, pr_busy, dbg, err}
    function automatic logic [9:0] obs_v();
        return {ctrl_if.ul_lphy_oran_clear, ctrl_if.ul_lphy_oran_fifo_reset, ul_done,
                ctrl_if.prach_oran_clear, ctrl_if.prach_oran_fifo_reset, prach_done,
                ul_busy, prach_busy, ctrl_if.lphy_oran_dbg_clear, bnd_timeout_err};
    endfunction

    // Clear at clr, fifo reset clr+1..clr+16, done at clr+16+8+1
    function automatic logic [2:0] sb(int c, int clr);
        return {c == clr, (c >= clr + 1) && (c <= clr + 16), c == clr + 25};
    endfunction

    function automatic logic in_rng(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic chk(string tag, int c, logic [9:0] o, logic [9:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, o, e);
        end
    endtask

    task automatic drive(logic u, logic p, logic d, logic s);
        ul_req        = u;
        prach_req     = p;
        dbg_clear_req = d;
        sym_strobe    = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", -1, obs_v(), 10'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // UL only, boundary at 10
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            drive(c == 0, 1'b0, 1'b0, c == 10);
            e = {sb(c, 11), 3'b000, in_rng(c, 1, 36), 1'b0, 1'b0, 1'b0};
            chk("ul_only", c, obs_v(), e);
        end

        // Simultaneous requests, strobes every 50
        do_reset();
        for (int c = 0; c <= 130; c++) begin
            @(posedge clk); #1;
            drive(c == 0, c == 0, 1'b0, (c > 0) && (c % 50 == 0));
            e = {sb(c, 51), sb(c, 101), in_rng(c, 1, 76), in_rng(c, 1, 126), 1'b0, 1'b0};
            chk("both_req", c, obs_v(), e);
        end

        // PRACH boundary timeout, then a UL sequence with the flag still set
        do_reset();
        for (int c = 0; c <= 170; c++) begin
            @(posedge clk); #1;
            drive(c == 130, c == 0, 1'b0, c == 140);
            e = {sb(c, 141), sb(c, 102), in_rng(c, 131, 166), in_rng(c, 1, 127), 1'b0, c >= 102};
            chk("timeout", c, obs_v(), e);
        end

        // Strobe on the timeout cycle counts as a boundary
        do_reset();
        for (int c = 0; c <= 130; c++) begin
            @(posedge clk); #1;
            drive(c == 0, 1'b0, 1'b0, c == 101);
            e = {sb(c, 102), 3'b000, in_rng(c, 1, 127), 1'b0, 1'b0, 1'b0};
            chk("strobe_at_timeout", c, obs_v(), e);
        end

        // UL re-request during RESET gives a second full sequence
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            @(posedge clk); #1;
            drive((c == 0) || (c == 20), 1'b0, 1'b0, (c == 10) || (c == 50));
            e = {sb(c, 11) | sb(c, 51), 3'b000, in_rng(c, 1, 76), 1'b0, 1'b0, 1'b0};
            chk("ul_rereq", c, obs_v(), e);
        end

        // Asynchronous reset while fifo reset is high
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            drive(c == 0, 1'b0, 1'b0, c == 10);
            if (c == 17) rst = 1'b0;
            e = (c <= 15) ? {sb(c, 11), 3'b000, in_rng(c, 1, 36), 1'b0, 1'b0, 1'b0} : 10'b0;
            chk("rst_mid_seq", c, obs_v(), e);
            if (c == 15) begin
                rst = 1'b1;
                #2;
                chk("rst_async_drop", c, obs_v(), 10'b0);
            end
        end

        // Debug clear during a PRACH sequence; strobe while IDLE ignored
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            @(posedge clk); #1;
            drive(1'b0, c == 0, c == 5, (c == 1) || (c == 4));
            e = {3'b000, sb(c, 5), 1'b0, in_rng(c, 1, 30), c == 6, 1'b0};
            chk("dbg_clear", c, obs_v(), e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jb_oran_lphy_rst_seq.md
# jb_oran_lphy_rst_seq

Reset/clear sequencer for the O-RAN low-PHY UL and PRACH paths. It accepts software-level reset requests for each path and arbitrates them onto a single shared sequencer. The sequencer aligns each request to a symbol boundary, then drives the path's `*_clear` and `*_fifo_reset` controls in a fixed order with programmable hold and settle times. It sits between the register block and the low-PHY control interface; its outputs drive the lphy control interface's clear/reset fields.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `*_fifo_reset` is held high (1..2^CNT_W-1).
- `SETTLE_CYCLES`, 8: idle cycles after reset release before done (0..2^CNT_W-1).
- `BND_TIMEOUT`, 65535: max cycles waiting for `sym_strobe` before forced progress (≥1).
- `CNT_W`, 16: counter width.

Ports (clock/reset: one clock; reset is asynchronous and active-high):
- `clk` in 1: block clock.
- `rst` in 1: asynchronous, active-high reset.
- `ul_req` in 1: UL reset request pulse.
- `prach_req` in 1: PRACH reset request pulse.
- `dbg_clear_req` in 1: debug-counter clear request.
- `sym_strobe` in 1: one-cycle symbol-boundary strobe from timing.
- `ul_lphy_oran_clear` out 1: UL clear pulse.
- `ul_lphy_oran_fifo_reset` out 1: UL FIFO reset level.
- `prach_oran_clear` out 1: PRACH clear pulse.
- `prach_oran_fifo_reset` out 1: PRACH FIFO reset level.
- `lphy_oran_dbg_clear` out 1: debug clear pulse.
- `ul_busy`, `prach_busy` out 1: the path has a pending or in-progress request.
- `ul_done`, `prach_done` out 1: one-cycle completion pulse.
- `bnd_timeout_err` out 1: sticky flag, set when a boundary wait times out; cleared only by `rst`.

## Operation
- Requests are latched into `pend_ul` and `pend_prach`, set the cycle after the request is seen. A request arriving while its own path is being sequenced re-sets the pend bit, and the path is serviced again afterward.
- Arbitration is two-way round-robin. A `last` flag records the last path served; its reset value is PRACH, so UL wins the first tie.
- FSM states and transitions:
  - IDLE: if any pend bit is set, select a path, clear its pend bit, load the counter with 0, go to WAIT_BND.
  - WAIT_BND: count cycles. On `sym_strobe`, go to CLEAR. If the count reaches BND_TIMEOUT-1 without `sym_strobe`, set `bnd_timeout_err` and go to CLEAR.
  - CLEAR: exactly 1 cycle. The selected `*_clear` is high. Go to RESET.
  - RESET: the selected `*_fifo_reset` is high for RST_CYCLES cycles, then go to SETTLE, or to DONE if SETTLE_CYCLES = 0.
  - SETTLE: SETTLE_CYCLES cycles with all controls low, then go to DONE.
  - DONE: 1 cycle. The selected `*_done` is high, `last` is updated, go to IDLE.
- `*_busy` = pend bit OR (FSM not IDLE AND the path is selected).
- `lphy_oran_dbg_clear` is `dbg_clear_req` registered, one cycle later. It is independent of the FSM.
- Only one path is ever in CLEAR/RESET at a time. The non-selected path's outputs stay 0.
- Reset values of all outputs are 0. All FSM state, pend bits, counters and `bnd_timeout_err` return to IDLE/0. Asserting `rst` mid-sequence drops `*_fifo_reset` immediately (asynchronous) and discards pending requests.

## Timing
- All outputs are registered.
- Latency from request to clear: `req` in cycle n sets pend in n+1; IDLE→WAIT_BND in n+2.
  - If `sym_strobe` arrives in cycle m ≥ n+2, `*_clear` is high in m+1.
  - A `sym_strobe` in cycle n+1 (while still in IDLE) is ignored.
- Counting from clear in cycle c:
  - `*_fifo_reset` is high for cycles c+1 .. c+RST_CYCLES.
  - `*_done` is high in c+RST_CYCLES+SETTLE_CYCLES+1.
  - The next request's earliest WAIT_BND is c+RST_CYCLES+SETTLE_CYCLES+2.
- Simultaneous `ul_req` and `prach_req`: both latch. The first path is sequenced fully, then the second enters WAIT_BND in the cycle after the first's DONE.
- `sym_strobe` coinciding with the timeout cycle counts as a boundary; no error is flagged.

## Structure
- Package `jb_oran_lphy_seq_pkg` holds:
  - `seq_state_e`: IDLE, WAIT_BND, CLEAR, RESET, SETTLE, DONE.
  - `seq_path_e`: UL, PRACH.
- One sub-module, `jb_oran_lphy_rr_arb2`: two-request round-robin arbiter with a `last` register and a grant-accept input. Everything else stays in the top module.

## Test plan
- UL only, RST_CYCLES=16, SETTLE_CYCLES=8, `ul_req` @0, `sym_strobe` @10 → `ul_lphy_oran_clear` @11, `ul_lphy_oran_fifo_reset` @12..27, `ul_done` @36; PRACH outputs stay 0.
- `ul_req` and `prach_req` @0, strobes every 50 cycles from 50 → UL cleared @51, PRACH enters WAIT_BND @77 and clears @101; `prach_busy` is high from 1 to 126.
- No `sym_strobe`, BND_TIMEOUT=100, `prach_req` @0 → `bnd_timeout_err` set and `prach_oran_clear` follows at the timeout (clear @102); flag stays high through later sequences.
- `ul_req` re-pulsed @20 during the UL RESET state → a second full UL sequence starts after `ul_done`; exactly two `ul_done` pulses.
- `rst` asserted @15 while `ul_lphy_oran_fifo_reset` is high → output falls without a clock edge; after `rst` deasserts, no `ul_done` and busy=0.
- `dbg_clear_req` @5 during an active PRACH sequence → `lphy_oran_dbg_clear` high @6 only; the PRACH sequence timing is unchanged.
